// File: rtl/cpu_ctrl_param.sv
// Multicycle control unit for the switch-driven teaching CPU: sequences the
// 8-opcode ISA between keys/switches, register file, ALU and LCD driver.
module cpu_ctrl_param #(
  parameter int DATA_W       = 16,
  parameter int RA_W         = 4,
  parameter int IMM_W        = 6,
  parameter int INIT_TIMEOUT = 1_000_000,
  localparam int INSTR_W     = 3 + 2*RA_W + 1 + IMM_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_on,
  input  logic               key_send,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [DATA_W-1:0]  rf_rdata_a,
  input  logic [DATA_W-1:0]  rf_rdata_b,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               lcd_init_done,
  input  logic               disp_ready,
  output logic               led_off,
  output logic               led_ready,
  output logic               init_err,
  output logic [RA_W-1:0]    rf_raddr_a,
  output logic [RA_W-1:0]    rf_raddr_b,
  output logic [RA_W-1:0]    rf_waddr,
  output logic               rf_we,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [2:0]         alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic               lcd_init_start,
  output logic               disp_valid,
  output logic [DATA_W-1:0]  disp_data
);

  localparam int CNT_W  = $clog2(INIT_TIMEOUT + 1);
  localparam int RD_HI  = INSTR_W - 4;
  localparam int RS1_HI = RD_HI - RA_W;
  localparam int RS2_HI = RS1_HI - RA_W;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_DISP  = 3'b111;

  typedef enum logic [2:0] {
    S_OFF, S_INIT, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_DISPLAY
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         key_on_sync_q, key_on_sync_d, key_send_sync_q, key_send_sync_d;
  logic               key_on_prev_q, key_on_prev_d, key_send_prev_q, key_send_prev_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               init_err_q, init_err_d;
  logic               lcd_init_start_q, lcd_init_start_d;
  logic               rf_we_q, rf_we_d;
  logic               alu_wb_q, alu_wb_d;
  logic [RA_W-1:0]    rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic               disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0]  disp_data_q, disp_data_d;

  logic              key_on_evt, key_send_evt;
  logic [2:0]        opcode;
  logic [RA_W-1:0]   rd, rs1, rs2;
  logic [DATA_W-1:0] alu_imm, load_imm;

  // Sign bit negates the unsigned magnitude field.
  function automatic logic [DATA_W-1:0] smag(input logic sign, input logic [IMM_W-1:0] mag);
    logic [DATA_W-1:0] ext;
    ext = {{(DATA_W-IMM_W){1'b0}}, mag};
    return sign ? -ext : ext;
  endfunction

  assign key_on_evt   = ~key_on_sync_q[1] & key_on_prev_q;
  assign key_send_evt = ~key_send_sync_q[1] & key_send_prev_q;

  assign opcode   = instr_q[INSTR_W-1 -: 3];
  assign rd       = instr_q[RD_HI -: RA_W];
  assign rs1      = instr_q[RS1_HI -: RA_W];
  assign rs2      = instr_q[RS2_HI -: RA_W];
  assign alu_imm  = smag(instr_q[IMM_W], instr_q[IMM_W-1:0]);
  assign load_imm = smag(instr_q[RS1_HI], instr_q[RS1_HI-1 -: IMM_W]);

  // Port A reads rd during DECODE so DISPLAY can capture it on the way out.
  assign rf_raddr_a = (opcode == OP_CLEAR || opcode == OP_DISP) ? rd : rs1;
  assign rf_raddr_b = rs2;

  always_comb begin
    key_on_sync_d    = {key_on_sync_q[0], key_on};
    key_on_prev_d    = key_on_sync_q[1];
    key_send_sync_d  = {key_send_sync_q[0], key_send};
    key_send_prev_d  = key_send_sync_q[1];
    state_d          = state_q;
    instr_d          = instr_q;
    cnt_d            = cnt_q;
    init_err_d       = init_err_q;
    lcd_init_start_d = 1'b0;
    rf_we_d          = rf_we_q;
    alu_wb_d         = alu_wb_q;
    rf_waddr_d       = rf_waddr_q;
    wdata_d          = wdata_q;
    alu_op_d         = alu_op_q;
    alu_a_d          = alu_a_q;
    alu_b_d          = alu_b_q;
    disp_valid_d     = disp_valid_q;
    disp_data_d      = disp_data_q;

    case (state_q)
      S_OFF: begin
        if (key_on_evt) begin
          state_d          = S_INIT;
          lcd_init_start_d = 1'b1;
          init_err_d       = 1'b0;
          cnt_d            = '0;
        end
      end
      S_INIT: begin
        if (cnt_q != CNT_W'(INIT_TIMEOUT)) cnt_d = cnt_q + CNT_W'(1);
        if (lcd_init_done) begin
          state_d = S_FETCH;
        end else if (cnt_q >= CNT_W'(INIT_TIMEOUT - 1)) begin
          state_d    = S_OFF;
          init_err_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (key_send_evt) begin
          instr_d = instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd;
            wdata_d    = load_imm;
            state_d    = S_WRITEBACK;
          end
          OP_CLEAR: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd;
            wdata_d    = '0;
            state_d    = S_DISPLAY;
          end
          OP_DISP: begin
            disp_valid_d = 1'b1;
            disp_data_d  = rf_rdata_a;
            state_d      = S_DISPLAY;
          end
          default: state_d = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        alu_a_d    = rf_rdata_a;
        alu_b_d    = (opcode == OP_ADD || opcode == OP_SUB) ? rf_rdata_b : alu_imm;
        alu_op_d   = opcode;
        rf_we_d    = 1'b1;
        alu_wb_d   = 1'b1;
        rf_waddr_d = rd;
        state_d    = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        rf_we_d  = 1'b0;
        alu_wb_d = 1'b0;
        state_d  = S_FETCH;
      end
      S_DISPLAY: begin
        if (opcode == OP_CLEAR) begin
          rf_we_d = 1'b0;
          state_d = S_FETCH;
        end else if (disp_ready) begin
          disp_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end
      default: state_d = S_OFF;
    endcase

    // Power key aborts whatever is in flight, including a pending key_send.
    if (key_on_evt && state_q != S_OFF) begin
      state_d          = S_OFF;
      rf_we_d          = 1'b0;
      alu_wb_d         = 1'b0;
      disp_valid_d     = 1'b0;
      lcd_init_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_OFF;
      key_on_sync_q    <= '0;
      key_on_prev_q    <= 1'b0;
      key_send_sync_q  <= '0;
      key_send_prev_q  <= 1'b0;
      instr_q          <= '0;
      cnt_q            <= '0;
      init_err_q       <= 1'b0;
      lcd_init_start_q <= 1'b0;
      rf_we_q          <= 1'b0;
      alu_wb_q         <= 1'b0;
      rf_waddr_q       <= '0;
      wdata_q          <= '0;
      alu_op_q         <= '0;
      alu_a_q          <= '0;
      alu_b_q          <= '0;
      disp_valid_q     <= 1'b0;
      disp_data_q      <= '0;
    end else begin
      state_q          <= state_d;
      key_on_sync_q    <= key_on_sync_d;
      key_on_prev_q    <= key_on_prev_d;
      key_send_sync_q  <= key_send_sync_d;
      key_send_prev_q  <= key_send_prev_d;
      instr_q          <= instr_d;
      cnt_q            <= cnt_d;
      init_err_q       <= init_err_d;
      lcd_init_start_q <= lcd_init_start_d;
      rf_we_q          <= rf_we_d;
      alu_wb_q         <= alu_wb_d;
      rf_waddr_q       <= rf_waddr_d;
      wdata_q          <= wdata_d;
      alu_op_q         <= alu_op_d;
      alu_a_q          <= alu_a_d;
      alu_b_q          <= alu_b_d;
      disp_valid_q     <= disp_valid_d;
      disp_data_q      <= disp_data_d;
    end
  end

  assign led_off        = (state_q == S_OFF);
  assign led_ready      = (state_q == S_FETCH);
  assign init_err       = init_err_q;
  assign lcd_init_start = lcd_init_start_q;
  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  // ALU writebacks take the live ALU output fed from the registered operands.
  assign rf_wdata       = alu_wb_q ? alu_result : wdata_q;
  assign alu_op         = alu_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign disp_valid     = disp_valid_q;
  assign disp_data      = disp_data_q;

endmodule

// File: tb/tb_cpu_ctrl_param.sv
// Testbench for cpu_ctrl_param: register-file/ALU models around the DUT and a
// scoreboard of expected register writes and display words.
module tb_cpu_ctrl_param;

  localparam int DATA_W  = 16;
  localparam int RA_W    = 4;
  localparam int IMM_W   = 6;
  localparam int INSTR_W = 18;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, key_on, key_send, lcd_init_done, disp_ready;
  logic [INSTR_W-1:0] instr_in;
  logic [DATA_W-1:0]  rf_rdata_a, rf_rdata_b, alu_result;
  logic               led_off, led_ready, init_err, rf_we, lcd_init_start, disp_valid;
  logic [RA_W-1:0]    rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [DATA_W-1:0]  rf_wdata, alu_a, alu_b, disp_data;
  logic [2:0]         alu_op;

  cpu_ctrl_param #(
    .DATA_W(DATA_W), .RA_W(RA_W), .IMM_W(IMM_W), .INIT_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .key_on(key_on), .key_send(key_send),
    .instr_in(instr_in), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_result(alu_result), .lcd_init_done(lcd_init_done), .disp_ready(disp_ready),
    .led_off(led_off), .led_ready(led_ready), .init_err(init_err),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .lcd_init_start(lcd_init_start), .disp_valid(disp_valid), .disp_data(disp_data)
  );

  typedef struct packed {
    logic [RA_W-1:0]   addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               wr_q[$];
  logic [DATA_W-1:0] disp_q[$];
  logic [DATA_W-1:0] rf_model [16];
  int total = 0;
  int passed = 0;
  int wr_count = 0;
  int start_count = 0;

  // ALU op table: instruction, expected operands and writeback
  logic [INSTR_W-1:0] t_instr [5] = '{
    {3'b010, 4'd4, 4'd3, 1'b0, 6'd7},
    {3'b001, 4'd5, 4'd4, 4'd3, 3'b000},
    {3'b011, 4'd6, 4'd4, 4'd3, 3'b000},
    {3'b100, 4'd7, 4'd4, 1'b1, 6'd3},
    {3'b101, 4'd8, 4'd6, 1'b0, 6'd3}
  };
  logic [2:0]        t_op   [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b101};
  logic [DATA_W-1:0] t_a    [5] = '{16'hFFFB, 16'h0002, 16'h0002, 16'h0002, 16'h0007};
  logic [DATA_W-1:0] t_b    [5] = '{16'h0007, 16'hFFFB, 16'hFFFB, 16'hFFFD, 16'h0003};
  logic [RA_W-1:0]   t_addr [5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
  logic [DATA_W-1:0] t_res  [5] = '{16'h0002, 16'hFFFD, 16'h0007, 16'h0005, 16'h0015};

  assign rf_rdata_a = rf_model[rf_raddr_a];
  assign rf_rdata_b = rf_model[rf_raddr_b];

  always_comb begin
    case (alu_op)
      3'b001, 3'b010: alu_result = alu_a + alu_b;
      3'b011, 3'b100: alu_result = alu_a - alu_b;
      3'b101:         alu_result = alu_a * alu_b;
      default:        alu_result = '0;
    endcase
  end

  always @(posedge clk) begin
    if (reset && rf_we) begin
      rf_model[rf_waddr] <= rf_wdata;
      wr_count = wr_count + 1;
    end
    if (lcd_init_start) start_count = start_count + 1;
  end

  task automatic press_on();
    @(negedge clk) key_on = 1'b0;
    repeat (2) @(negedge clk);
    key_on = 1'b1;
  endtask

  task automatic press_send(input bit hold);
    @(negedge clk) key_send = 1'b0;
    repeat (2) @(negedge clk);
    if (!hold) key_send = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; key_on = 1'b1; key_send = 1'b1; lcd_init_done = 1'b0;
    disp_ready = 1'b0; instr_in = '0;
    for (int i = 0; i < 16; i++) rf_model[i] = '0;
    repeat (3) @(negedge clk);
    total++; if (led_off !== 1'b1) $display("[TB] FAIL reset_led_off: got %b expected 1", led_off); else passed++;
    total++; if ({led_ready, init_err, rf_we, lcd_init_start, disp_valid} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000", {led_ready, init_err, rf_we, lcd_init_start, disp_valid}); else passed++;
    total++; if ({rf_waddr, rf_wdata, alu_op, alu_a, alu_b, disp_data} !== '0)
      $display("[TB] FAIL reset_data: got %h expected 0", {rf_waddr, rf_wdata, alu_op, alu_a, alu_b, disp_data}); else passed++;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (led_off !== 1'b1) $display("[TB] FAIL idle_off: got %b expected 1", led_off); else passed++;
  endtask

  task automatic test_power_on();
    start_count = 0;
    press_on();
    @(negedge clk);
    total++; if (lcd_init_start !== 1'b1) $display("[TB] FAIL init_start_pulse: got %b expected 1", lcd_init_start); else passed++;
    total++; if (led_off !== 1'b0) $display("[TB] FAIL init_led_off: got %b expected 0", led_off); else passed++;
    @(negedge clk);
    total++; if ({lcd_init_start, led_ready} !== 2'b00) $display("[TB] FAIL init_wait: got %b expected 00", {lcd_init_start, led_ready}); else passed++;
    repeat (8) @(negedge clk);
    lcd_init_done = 1'b1;
    @(negedge clk);
    lcd_init_done = 1'b0;
    total++; if (led_ready !== 1'b1) $display("[TB] FAIL init_ready: got %b expected 1", led_ready); else passed++;
    total++; if (start_count !== 1) $display("[TB] FAIL init_start_count: got %0d expected 1", start_count); else passed++;
  endtask

  task automatic test_load();
    wr_t exp;
    int  w0;
    repeat (3) @(negedge clk);
    instr_in = {3'b000, 4'd3, 1'b1, 6'd5, 4'b0000};
    wr_q.push_back(wr_t'{addr: 4'd3, data: 16'hFFFB});
    w0 = wr_count;
    press_send(1'b0);
    total++; if (led_ready !== 1'b1) $display("[TB] FAIL load_fetch: got %b expected 1", led_ready); else passed++;
    @(negedge clk);
    total++; if ({led_ready, rf_we} !== 2'b00) $display("[TB] FAIL load_decode: got %b expected 00", {led_ready, rf_we}); else passed++;
    @(negedge clk);
    exp = wr_q.pop_front();
    total++; if (rf_we !== 1'b1) $display("[TB] FAIL load_we: got %b expected 1", rf_we); else passed++;
    total++; if ({rf_waddr, rf_wdata} !== {exp.addr, exp.data})
      $display("[TB] FAIL load_write: got %h/%h expected %h/%h", rf_waddr, rf_wdata, exp.addr, exp.data); else passed++;
    @(negedge clk);
    total++; if ({rf_we, led_ready} !== 2'b01) $display("[TB] FAIL load_done: got %b expected 01", {rf_we, led_ready}); else passed++;
    total++; if (wr_count !== w0 + 1) $display("[TB] FAIL load_count: got %0d expected %0d", wr_count, w0 + 1); else passed++;
  endtask

  task automatic test_alu_ops();
    wr_t exp;
    for (int k = 0; k < 5; k++) begin
      repeat (3) @(negedge clk);
      instr_in = t_instr[k];
      wr_q.push_back(wr_t'{addr: t_addr[k], data: t_res[k]});
      press_send(1'b0);
      @(negedge clk);
      @(negedge clk);
      total++; if ({rf_we, led_ready} !== 2'b00) $display("[TB] FAIL alu%0d_execute: got %b expected 00", k, {rf_we, led_ready}); else passed++;
      @(negedge clk);
      exp = wr_q.pop_front();
      total++; if (rf_we !== 1'b1) $display("[TB] FAIL alu%0d_we: got %b expected 1", k, rf_we); else passed++;
      total++; if ({alu_op, alu_a, alu_b} !== {t_op[k], t_a[k], t_b[k]})
        $display("[TB] FAIL alu%0d_operands: got %b/%h/%h expected %b/%h/%h", k, alu_op, alu_a, alu_b, t_op[k], t_a[k], t_b[k]); else passed++;
      total++; if ({rf_waddr, rf_wdata} !== {exp.addr, exp.data})
        $display("[TB] FAIL alu%0d_write: got %h/%h expected %h/%h", k, rf_waddr, rf_wdata, exp.addr, exp.data); else passed++;
      @(negedge clk);
      total++; if ({rf_we, led_ready} !== 2'b01) $display("[TB] FAIL alu%0d_done: got %b expected 01", k, {rf_we, led_ready}); else passed++;
    end
  endtask

  task automatic test_display_stall();
    logic [DATA_W-1:0] exp;
    bit stable;
    repeat (3) @(negedge clk);
    instr_in = {3'b111, 4'd4, 11'b0};
    disp_q.push_back(16'h0002);
    disp_ready = 1'b0;
    press_send(1'b1);
    @(negedge clk);
    total++; if (disp_valid !== 1'b0) $display("[TB] FAIL disp_decode: got %b expected 0", disp_valid); else passed++;
    @(negedge clk);
    exp = disp_q.pop_front();
    total++; if ({disp_valid, disp_data} !== {1'b1, exp}) $display("[TB] FAIL disp_rise: got %b/%h expected 1/%h", disp_valid, disp_data, exp); else passed++;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (disp_valid !== 1'b1 || disp_data !== exp) stable = 1'b0;
      if (i < 19) @(negedge clk);
    end
    total++; if (stable !== 1'b1) $display("[TB] FAIL disp_hold: got %b expected 1", stable); else passed++;
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
    total++; if ({disp_valid, led_ready} !== 2'b01) $display("[TB] FAIL disp_drop: got %b expected 01", {disp_valid, led_ready}); else passed++;
    repeat (5) @(negedge clk);
    total++; if (led_ready !== 1'b1) $display("[TB] FAIL send_held_retrigger: got %b expected 1", led_ready); else passed++;
    key_send = 1'b1;
  endtask

  task automatic test_display_fast();
    logic [DATA_W-1:0] exp;
    repeat (4) @(negedge clk);
    instr_in = {3'b111, 4'd7, 11'b0};
    disp_q.push_back(16'h0005);
    disp_ready = 1'b1;
    press_send(1'b0);
    @(negedge clk);
    @(negedge clk);
    exp = disp_q.pop_front();
    total++; if ({disp_valid, disp_data} !== {1'b1, exp}) $display("[TB] FAIL fast_valid: got %b/%h expected 1/%h", disp_valid, disp_data, exp); else passed++;
    @(negedge clk);
    total++; if ({disp_valid, led_ready} !== 2'b01) $display("[TB] FAIL fast_done: got %b expected 01", {disp_valid, led_ready}); else passed++;
    disp_ready = 1'b0;
  endtask

  task automatic test_clear();
    wr_t exp;
    repeat (3) @(negedge clk);
    instr_in = {3'b110, 4'd5, 11'b0};
    wr_q.push_back(wr_t'{addr: 4'd5, data: 16'h0000});
    press_send(1'b0);
    @(negedge clk);
    total++; if (rf_we !== 1'b0) $display("[TB] FAIL clear_decode: got %b expected 0", rf_we); else passed++;
    @(negedge clk);
    exp = wr_q.pop_front();
    total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, exp.addr, exp.data})
      $display("[TB] FAIL clear_write: got %b/%h/%h expected 1/%h/%h", rf_we, rf_waddr, rf_wdata, exp.addr, exp.data); else passed++;
    @(negedge clk);
    total++; if ({rf_we, led_ready} !== 2'b01) $display("[TB] FAIL clear_done: got %b expected 01", {rf_we, led_ready}); else passed++;
  endtask

  task automatic test_abort_display();
    int w0;
    repeat (3) @(negedge clk);
    instr_in = {3'b111, 4'd6, 11'b0};
    disp_ready = 1'b0;
    w0 = wr_count;
    press_send(1'b0);
    @(negedge clk);
    @(negedge clk);
    press_on();
    total++; if (disp_valid !== 1'b1) $display("[TB] FAIL abort_pending: got %b expected 1", disp_valid); else passed++;
    @(negedge clk);
    total++; if ({led_off, disp_valid, rf_we} !== 3'b100) $display("[TB] FAIL abort_off: got %b expected 100", {led_off, disp_valid, rf_we}); else passed++;
    total++; if (wr_count !== w0) $display("[TB] FAIL abort_nowrite: got %0d expected %0d", wr_count, w0); else passed++;
  endtask

  task automatic test_timeout();
    repeat (3) @(negedge clk);
    press_on();
    @(negedge clk);
    total++; if ({led_off, init_err} !== 2'b00) $display("[TB] FAIL to_enter: got %b expected 00", {led_off, init_err}); else passed++;
    repeat (TIMEOUT - 1) @(negedge clk);
    total++; if (led_off !== 1'b0) $display("[TB] FAIL to_last_init: got %b expected 0", led_off); else passed++;
    @(negedge clk);
    total++; if ({led_off, init_err} !== 2'b11) $display("[TB] FAIL to_expired: got %b expected 11", {led_off, init_err}); else passed++;
    repeat (3) @(negedge clk);
    total++; if (init_err !== 1'b1) $display("[TB] FAIL to_err_hold: got %b expected 1", init_err); else passed++;
    press_on();
    @(negedge clk);
    total++; if ({init_err, led_off} !== 2'b00) $display("[TB] FAIL to_err_clear: got %b expected 00", {init_err, led_off}); else passed++;
    repeat (TIMEOUT - 1) @(negedge clk);
    lcd_init_done = 1'b1;
    @(negedge clk);
    lcd_init_done = 1'b0;
    total++; if ({led_ready, init_err} !== 2'b10) $display("[TB] FAIL to_done_wins: got %b expected 10", {led_ready, init_err}); else passed++;
  endtask

  task automatic test_reset_writeback();
    int w0;
    repeat (3) @(negedge clk);
    instr_in = {3'b010, 4'd9, 4'd3, 1'b0, 6'd1};
    w0 = wr_count;
    press_send(1'b0);
    repeat (3) @(negedge clk);
    total++; if (rf_we !== 1'b1) $display("[TB] FAIL rstwb_pending: got %b expected 1", rf_we); else passed++;
    #1 reset = 1'b0;
    #1;
    total++; if ({led_off, rf_we, disp_valid} !== 3'b100) $display("[TB] FAIL rstwb_async: got %b expected 100", {led_off, rf_we, disp_valid}); else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (wr_count !== w0 || rf_model[9] !== 16'h0000)
      $display("[TB] FAIL rstwb_nowrite: got %0d/%h expected %0d/0000", wr_count, rf_model[9], w0); else passed++;
    total++; if (wr_q.size() + disp_q.size() !== 0)
      $display("[TB] FAIL scoreboard_drain: got %0d expected 0", wr_q.size() + disp_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_load();
    test_alu_ops();
    test_display_stall();
    test_display_fast();
    test_clear();
    test_abort_display();
    test_timeout();
    test_reset_writeback();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
